ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute pipeline stage of the in-order RV32IM core, directly upstream of the memory stage.
- Consumes the registered ID/EX bundle and computes ALU results and load/store addresses.
- Runs an iterative RV32M multiply/divide unit that stalls the front end.
- Registers the existing pipeline_types::ex_mem_t bundle consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_EN, 1, set to 1 to instantiate the multiply/divide unit; when 0, func7=0000001 ops are executed as bubbles.

Ports:
- iClk  in  1  clock.
- nRst  in  1  reset, asynchronous, active-low.
- iEn  in  1  stage enable. When low, no new op starts and a bubble is emitted.
- iStall  in  1  downstream (memory stage) stall. When high, oEX holds.
- iID  in  id_ex_t  decoded instruction: ctrl, rs1/rs2 values, imm, rd.addr.
- oEX  out  ex_mem_t  registered result to the memory stage.
- oStall  out  1  upstream stall while mul/div is pending. iID must be held stable while oStall is high.

Behaviour:
- Reset:
  - oEX = '0 (ctrl.valid=0).
  - FSM = IDLE, counter = 0.
  - oStall = 0 while nRst is low.
  - Asserting reset mid-operation aborts the mul/div immediately, with no result.
- ALU op (iID.ctrl.valid & ~md):
  - 1-cycle latency; oEX is loaded at the next posedge if !iStall.
  - Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, selected by func3/func7[5].
  - Operand B is imm when ctrl.imm_sel is set, else rs2.
  - Shifts use B[4:0].
  - All arithmetic is mod 2^32; overflow wraps and never traps.
- Memory op (ctrl.mem_en):
  - oEX.rd.value = rs1 + imm (address).
  - oEX.rs.value = rs2 (store data).
- Pass-through fields:
  - oEX.ctrl = iID.ctrl unchanged, including valid, mem_en, wb_en, func3.
  - oEX.rd.addr = iID.rd.addr.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when iEn & valid & md & MD_EN, regardless of iStall. Operands, signs and op are latched; counter = 0.
  - BUSY: one radix-2 step per cycle (shift-add multiply or restoring divide) on absolute values; counter increments. BUSY -> DONE when counter == 31 (32 steps).
  - DONE: applies sign correction and selects the result. At the posedge with !iStall, the result is written to oEX and the FSM returns to IDLE. If iStall, the FSM remains in DONE.
- Mul/div ops:
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- oStall is combinational: (IDLE & start condition) | BUSY.
  - High for exactly 33 cycles per mul/div op.
  - Low in DONE, so upstream advances on the same edge the result is written.
- While oStall is high and !iStall, oEX gets a bubble (ctrl.valid=0) each edge, so the memory stage never re-executes.
- Divide edge cases:
  - Divide by zero: quotient = 0xFFFFFFFF (also for DIVU); remainder = dividend.
  - Signed overflow 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
  - Neither case takes an early exit; both keep the fixed 33-cycle latency.
- Remainder sign follows the dividend; quotient sign is the XOR of operand signs.
- iStall during BUSY: iteration continues and oEX holds.
- iEn low:
  - Blocks new starts; an in-flight op still completes.
  - oEX gets a bubble unless iStall is high.
- Invalid input (ctrl.valid=0) produces a bubble; the FSM does not start.

Decomposition:
- pipeline_types additions:
  - id_ex_t struct: ctrl {valid, mem_en, wb_en, imm_sel, md, func3, func7}, rs1, rs2, imm, rd.addr.
  - alu_op_e enum.
  - Constants FUNC7_ALT = 7'b0100000 and FUNC7_MD = 7'b0000001.
- One sub-module, muldiv_iter:
  - Contains the FSM, counter, accumulator/remainder registers and sign fix-up.
  - Interface: start/op/a/b in; busy/done/result out; ack to pop the DONE state.
  - The ALU stays inline in ex_stage.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1 -> oEX.rd.value=0x80000000 one edge later. SRA 0x80000000 by imm 4 -> 0xF8000000.
- Store, rs1=0x1000, imm=-4, rs2=0xDEADBEEF -> rd.value=0x00000FFC, rs.value=0xDEADBEEF, ctrl passed through unchanged.
- MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - oStall high for 33 cycles.
  - oEX shows bubbles during the stall.
  - Result is valid on the 34th edge.
- DIV 7 / 0 -> 0xFFFFFFFF. REM 7 / 0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -7 / 2 -> 0xFFFFFFFF.
- DIVU in DONE with iStall high for 5 cycles -> FSM stays in DONE and oEX holds the prior value. Result is written on the first edge after iStall drops.
- nRst pulsed at BUSY counter=10 -> oEX=0, oStall=0. A subsequent ADD completes in 1 cycle.

Source files
------------

// File: rtl/pipeline_types.sv
// Shared pipeline types for the RV32IM core: ID/EX and EX/MEM bundles,
// ALU and mul/div operation encodings, and the decode helper for the ALU.
package pipeline_types;

    localparam logic [6:0] FUNC7_ALT = 7'b0100000;
    localparam logic [6:0] FUNC7_MD  = 7'b0000001;

    typedef struct packed {
        logic       valid;
        logic       mem_en;
        logic       wb_en;
        logic       imm_sel;
        logic       md;
        logic [2:0] func3;
        logic [6:0] func7;
    } ctrl_t;

    typedef struct packed {
        logic [4:0] addr;
    } rd_addr_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        rd_addr_t    rd;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] value;
    } rd_res_t;

    typedef struct packed {
        logic [31:0] value;
    } rs_res_t;

    typedef struct packed {
        ctrl_t   ctrl;
        rd_res_t rd;
        rs_res_t rs;
    } ex_mem_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // Encoded exactly as func3 of the RV32M instructions.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    // Map func3 plus the func7 "alternate" bit onto an ALU operation.
    function automatic alu_op_e decode_alu(input logic [2:0] func3, input logic alt);
        case (func3)
            3'b000:  decode_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  decode_alu = ALU_SLL;
            3'b010:  decode_alu = ALU_SLT;
            3'b011:  decode_alu = ALU_SLTU;
            3'b100:  decode_alu = ALU_XOR;
            3'b101:  decode_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  decode_alu = ALU_OR;
            default: decode_alu = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M unit: 32 radix-2 steps on operand magnitudes (shift-add
// multiply or restoring divide), then sign fix-up held in DONE until acked.
module muldiv_iter
    import pipeline_types::*;
(
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iAck,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oResult
);

    md_state_e   state, stateNext;
    logic [4:0]  count;
    md_op_e      opReg;
    logic [31:0] aReg, bReg;      // operand magnitudes
    logic [31:0] hi, lo;          // product {hi,lo}, or remainder hi / quotient lo
    logic        negA, negB, bZero;

    md_op_e      opIn;
    logic        aSigned, bSigned, negAIn, negBIn;
    logic [31:0] absA, absB;
    logic [32:0] mulSum, divShift, divDiff;
    logic        divGe;
    logic [63:0] prodFix;
    logic [31:0] quoFix, remFix;

    // Operand signedness and magnitudes for an op about to start
    always_comb begin
        opIn    = md_op_e'(iOp);
        aSigned = opIn inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        bSigned = opIn inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        negAIn  = aSigned & iA[31];
        negBIn  = bSigned & iB[31];
        absA    = negAIn ? -iA : iA;
        absB    = negBIn ? -iB : iB;
    end

    // One radix-2 step of each algorithm; the op decides which is kept
    always_comb begin
        mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, aReg} : 33'd0);
        divShift = {hi, lo[31]};
        divGe    = divShift >= {1'b0, bReg};
        divDiff  = divShift - {1'b0, bReg};
    end

    // State register
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state <= MD_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves stateNext unassigned, which
        // would otherwise infer a latch.
        stateNext = state;
        case (state)
            MD_IDLE: if (iStart)         stateNext = MD_BUSY;
            MD_BUSY: if (count == 5'd31) stateNext = MD_DONE;
            MD_DONE: if (iAck)           stateNext = MD_IDLE;
            default:                     stateNext = MD_IDLE;
        endcase
    end

    // Operand latch on start, then iterate while BUSY
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            count <= '0;
            opReg <= MD_MUL;
            aReg  <= '0;
            bReg  <= '0;
            hi    <= '0;
            lo    <= '0;
            negA  <= 1'b0;
            negB  <= 1'b0;
            bZero <= 1'b0;
        end else if (state == MD_IDLE && iStart) begin
            count <= '0;
            opReg <= opIn;
            aReg  <= absA;
            bReg  <= absB;
            hi    <= '0;
            lo    <= opIn[2] ? absA : absB;
            negA  <= negAIn;
            negB  <= negBIn;
            bZero <= (iB == 32'd0);
        end else if (state == MD_BUSY) begin
            count <= count + 5'd1;
            if (opReg[2]) begin
                hi <= divGe ? divDiff[31:0] : divShift[31:0];
                lo <= {lo[30:0], divGe};
            end else begin
                hi <= mulSum[32:1];
                lo <= {mulSum[0], lo[31:1]};
            end
        end
    end

    // Sign correction and result select; divide by zero keeps an all-ones
    // quotient and a remainder equal to the dividend
    always_comb begin
        prodFix = (negA ^ negB) ? -{hi, lo} : {hi, lo};
        quoFix  = bZero ? 32'hFFFF_FFFF : ((negA ^ negB) ? -lo : lo);
        remFix  = negA ? -hi : hi;
        case (opReg)
            MD_MUL:                       oResult = prodFix[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: oResult = prodFix[63:32];
            MD_DIV, MD_DIVU:              oResult = quoFix;
            default:                      oResult = remFix;
        endcase
    end

    // Busy covers the start cycle too, so the front end stalls at once;
    // forced low during reset
    assign oBusy = nRst & ((state == MD_IDLE && iStart) || state == MD_BUSY);
    assign oDone = (state == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and address generation, plus the iterative
// mul/div unit that stalls the front end while it runs.
module ex_stage
    import pipeline_types::*;
#(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
)(
    input  logic    iClk,
    input  logic    nRst,
    input  logic    iEn,
    input  logic    iStall,
    input  id_ex_t  iID,
    output ex_mem_t oEX,
    output logic    oStall
);

    logic [XLEN-1:0] opB, aluRes, memAddr;
    logic [4:0]      shamt;
    alu_op_e         aluOp;
    logic            aluGo, mdStart;
    logic            mdStall, mdDone;
    logic [31:0]     mdResult;
    ctrl_t           mdCtrl;
    logic [4:0]      mdRdAddr;
    logic [31:0]     mdRs2;
    ex_mem_t         exNext;

    // Inline ALU and load/store address generation
    always_comb begin
        opB     = iID.ctrl.imm_sel ? iID.imm : iID.rs2;
        shamt   = opB[4:0];
        aluOp   = decode_alu(iID.ctrl.func3, |(iID.ctrl.func7 & FUNC7_ALT));
        memAddr = iID.rs1 + iID.imm;
        case (aluOp)
            ALU_ADD:  aluRes = iID.rs1 + opB;
            ALU_SUB:  aluRes = iID.rs1 - opB;
            ALU_SLL:  aluRes = iID.rs1 << shamt;
            ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(iID.rs1) < $signed(opB)};
            ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, iID.rs1 < opB};
            ALU_XOR:  aluRes = iID.rs1 ^ opB;
            ALU_SRL:  aluRes = iID.rs1 >> shamt;
            ALU_SRA:  aluRes = XLEN'($signed(iID.rs1) >>> shamt);
            ALU_OR:   aluRes = iID.rs1 | opB;
            default:  aluRes = iID.rs1 & opB;
        endcase
    end

    assign aluGo   = iEn & iID.ctrl.valid & ~iID.ctrl.md;
    assign mdStart = iEn & iID.ctrl.valid & iID.ctrl.md;

    generate
        if (MD_EN) begin : g_md
            muldiv_iter u_muldiv (
                .iClk    (iClk),
                .nRst    (nRst),
                .iStart  (mdStart),
                .iOp     (iID.ctrl.func3),
                .iA      (iID.rs1),
                .iB      (iID.rs2),
                .iAck    (~iStall),
                .oBusy   (mdStall),
                .oDone   (mdDone),
                .oResult (mdResult)
            );
        end else begin : g_no_md
            // Mul/div instructions fall through to the bubble path below.
            assign mdStall  = 1'b0;
            assign mdDone   = 1'b0;
            assign mdResult = '0;
        end
    endgenerate

    // Capture the mul/div instruction's side-band fields while it is stalled
    // so the result is tagged correctly even if upstream moves on in DONE
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            mdCtrl   <= '0;
            mdRdAddr <= '0;
            mdRs2    <= '0;
        end else if (mdStall) begin
            mdCtrl   <= iID.ctrl;
            mdRdAddr <= iID.rd.addr;
            mdRs2    <= iID.rs2;
        end
    end

    // Next EX/MEM bundle: mul/div result, bubble, or ALU/memory result
    always_comb begin
        exNext = '0;
        if (mdDone) begin
            exNext.ctrl     = mdCtrl;
            exNext.rd.addr  = mdRdAddr;
            exNext.rd.value = mdResult;
            exNext.rs.value = mdRs2;
        end else if (!mdStall && aluGo) begin
            exNext.ctrl     = iID.ctrl;
            exNext.rd.addr  = iID.rd.addr;
            exNext.rd.value = iID.ctrl.mem_en ? memAddr : aluRes;
            exNext.rs.value = iID.rs2;
        end
    end

    // EX/MEM pipeline register, held while the memory stage stalls
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oEX <= '0;
        end else if (!iStall) begin
            oEX <= exNext;
        end
    end

    assign oStall = mdStall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected bundles are queued when an op is
// driven and popped when the stage writes its result.
module tb_ex_stage;
    import pipeline_types::*;

    logic    iClk = 1'b0;
    logic    nRst;
    logic    iEn;
    logic    iStall;
    id_ex_t  iID;
    ex_mem_t oEX;
    logic    oStall;

    int vectors     = 0;
    int miscompares = 0;
    ex_mem_t sbQ[$];

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t aluVecs[8] = '{
        '{"sub",  3'b000, FUNC7_ALT, 32'd5,         32'd7,         32'hFFFF_FFFE},
        '{"sll",  3'b001, 7'd0,      32'd1,         32'h0000_003F, 32'h8000_0000},
        '{"slt",  3'b010, 7'd0,      32'hFFFF_FFFF, 32'd1,         32'd1},
        '{"sltu", 3'b011, 7'd0,      32'hFFFF_FFFF, 32'd1,         32'd0},
        '{"xor",  3'b100, 7'd0,      32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
        '{"srl",  3'b101, 7'd0,      32'h8000_0000, 32'd4,         32'h0800_0000},
        '{"or",   3'b110, 7'd0,      32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0},
        '{"and",  3'b111, 7'd0,      32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00}
    };

    ex_stage #(.XLEN(32), .MD_EN(1'b1)) dut (
        .iClk   (iClk),
        .nRst   (nRst),
        .iEn    (iEn),
        .iStall (iStall),
        .iID    (iID),
        .oEX    (oEX),
        .oStall (oStall)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic id_ex_t mk(input logic memEn, input logic immSel, input logic md,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [4:0] rd);
        id_ex_t id;
        id.ctrl.valid   = 1'b1;
        id.ctrl.mem_en  = memEn;
        id.ctrl.wb_en   = ~memEn;
        id.ctrl.imm_sel = immSel;
        id.ctrl.md      = md;
        id.ctrl.func3   = f3;
        id.ctrl.func7   = f7;
        id.rs1          = a;
        id.rs2          = b;
        id.imm          = imm;
        id.rd.addr      = rd;
        return id;
    endfunction

    task automatic push_exp(input logic [31:0] value);
        ex_mem_t e;
        e.ctrl     = iID.ctrl;
        e.rd.addr  = iID.rd.addr;
        e.rd.value = value;
        e.rs.value = iID.rs2;
        sbQ.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input logic chkRs);
        ex_mem_t e;
        vectors++;
        assert (sbQ.size() > 0) else begin
            miscompares++;
            $error("FAIL %s.queue: observed empty scoreboard expected an entry", tag);
        end
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check({tag, ".value"}, oEX.rd.value, e.rd.value);
            check({tag, ".addr"}, 32'(oEX.rd.addr), 32'(e.rd.addr));
            check({tag, ".ctrl"}, 32'(oEX.ctrl), 32'(e.ctrl));
            if (chkRs) check({tag, ".rs"}, oEX.rs.value, e.rs.value);
        end
    endtask

    task automatic alu(input string tag, input id_ex_t id, input logic [31:0] exp);
        iID = id;
        push_exp(exp);
        tick();
        pop_cmp(tag, id.ctrl.mem_en);
    endtask

    // Runs one mul/div op; doneStall > 0 holds iStall that many edges in DONE.
    task automatic md_run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int doneStall);
        int n;
        iID = mk(1'b0, 1'b0, 1'b1, f3, FUNC7_MD, a, b, 32'd0, 5'd9);
        push_exp(exp);
        #1;
        check({tag, ".stall_start"}, 32'(oStall), 32'd1);
        n = 0;
        while (oStall === 1'b1 && n < 50) begin
            tick();
            n++;
            if (n == 16) check({tag, ".bubble_mid"}, 32'(oEX.ctrl.valid), 32'd0);
        end
        check({tag, ".stall_cycles"}, 32'(n), 32'd33);
        check({tag, ".bubble_last"}, 32'(oEX.ctrl.valid), 32'd0);
        if (doneStall > 0) begin
            iStall = 1'b1;
            repeat (doneStall) begin
                tick();
                check({tag, ".done_hold_valid"}, 32'(oEX.ctrl.valid), 32'd0);
                check({tag, ".done_hold_value"}, oEX.rd.value, 32'd0);
                check({tag, ".done_stall"}, 32'(oStall), 32'd0);
            end
            iStall = 1'b0;
        end
        tick();
        pop_cmp(tag, 1'b0);
        iID = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        id_ex_t id;

        // Reset with a start-eligible mul/div op presented
        nRst   = 1'b0;
        iEn    = 1'b1;
        iStall = 1'b0;
        iID    = mk(1'b0, 1'b0, 1'b1, 3'b001, FUNC7_MD, 32'd3, 32'd4, 32'd0, 5'd1);
        #12;
        check("reset.oex", 32'(oEX.rd.value | 32'(oEX.ctrl)), 32'd0);
        check("reset.stall", 32'(oStall), 32'd0);
        iID = '0;
        #5;
        nRst = 1'b1;
        tick();

        // ALU
        alu("add_wrap", mk(1'b0, 1'b0, 1'b0, 3'b000, 7'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd3),
            32'h8000_0000);
        alu("srai", mk(1'b0, 1'b1, 1'b0, 3'b101, FUNC7_ALT, 32'h8000_0000, 32'd0, 32'd4, 5'd4),
            32'hF800_0000);
        for (int i = 0; i < 8; i++) begin
            alu(aluVecs[i].tag,
                mk(1'b0, 1'b0, 1'b0, aluVecs[i].f3, aluVecs[i].f7, aluVecs[i].a, aluVecs[i].b,
                   32'd0, 5'(i + 10)),
                aluVecs[i].exp);
        end
        alu("store", mk(1'b1, 1'b1, 1'b0, 3'b010, 7'd0, 32'h0000_1000, 32'hDEAD_BEEF,
                        32'hFFFF_FFFC, 5'd0), 32'h0000_0FFC);

        // Invalid input is a bubble
        id = mk(1'b0, 1'b0, 1'b0, 3'b000, 7'd0, 32'd1, 32'd2, 32'd0, 5'd7);
        id.ctrl.valid = 1'b0;
        iID = id;
        tick();
        check("invalid.bubble", 32'(oEX.ctrl.valid), 32'd0);

        // iEn low: bubble and no mul/div start
        alu("add_pre_en", mk(1'b0, 1'b0, 1'b0, 3'b000, 7'd0, 32'd2, 32'd3, 32'd0, 5'd8), 32'd5);
        iEn = 1'b0;
        tick();
        check("en_low.bubble", 32'(oEX.ctrl.valid), 32'd0);
        iID = mk(1'b0, 1'b0, 1'b1, 3'b000, FUNC7_MD, 32'd2, 32'd3, 32'd0, 5'd8);
        #1;
        check("en_low.no_stall", 32'(oStall), 32'd0);
        tick();
        check("en_low.no_start", 32'(oStall), 32'd0);
        iEn = 1'b1;
        iID = '0;
        tick();

        // Mul/div
        md_run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        md_run("mul",    3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 0);
        md_run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        md_run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        md_run("div_z",  3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 0);
        md_run("rem_z",  3'b110, 32'd7,         32'd0,         32'd7,         0);
        md_run("divu_z", 3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 0);
        md_run("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        md_run("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
        md_run("rem_n",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        md_run("div_n",  3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 0);
        md_run("divu_s", 3'b101, 32'd100,       32'd7,         32'd14,        5);
        md_run("remu",   3'b111, 32'd100,       32'd7,         32'd2,         0);

        // Reset mid-BUSY while the memory stage stalls
        alu("add_pre_rst", mk(1'b0, 1'b0, 1'b0, 3'b000, 7'd0, 32'd3, 32'd4, 32'd0, 5'd5), 32'd7);
        iStall = 1'b1;
        iID    = mk(1'b0, 1'b0, 1'b1, 3'b100, FUNC7_MD, 32'd100, 32'd7, 32'd0, 5'd6);
        repeat (11) tick();
        check("busy.hold", oEX.rd.value, 32'd7);
        check("busy.stall", 32'(oStall), 32'd1);
        nRst = 1'b0;
        #1;
        check("rst_mid.oex", 32'(oEX.rd.value | 32'(oEX.ctrl)), 32'd0);
        check("rst_mid.stall", 32'(oStall), 32'd0);
        #1;
        nRst   = 1'b1;
        iStall = 1'b0;
        alu("add_post_rst", mk(1'b0, 1'b0, 1'b0, 3'b000, 7'd0, 32'h10, 32'h20, 32'd0, 5'd3),
            32'h30);
        check("post_rst.stall", 32'(oStall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
